uart_loader: RTL
================

// Module: uart_loader
// PURPOSE
//  UART-side bus initiator: parses host command frames from the uart_rx byte stream,
//  issues word writes/reads on a memory port, and answers via the uart_tx byte handshake.
//  Sits beside pipeline_unit on the data_src/mmio memory port; muxed in while cpu_hold=1.
//  Used for program download, memory peek and CPU hold/release from the host.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  max idle cycles between bytes of one frame before abort
//  HOLD_AT_RESET   1       reset value of cpu_hold
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  rst            in   1   asynchronous reset, active-high
//  rx_data_valid  in   1   receiver holds a byte; level, stays high until rx_ack
//  rx_data        in   8   received byte, stable while rx_data_valid=1
//  rx_ack         out  1   1-cycle pulse: byte consumed, receiver may clear valid
//  tx_data_valid  out  1   byte offered to transmitter
//  tx_data        out  8   byte to send, stable while tx_data_valid=1
//  tx_ready       in   1   transmitter can accept; transfer when valid&&ready at edge
//  mem_addr       out  32  word address, bits[1:0] always 0
//  mem_wdata      out  32  write data
//  mem_we         out  1   1-cycle write strobe (full word)
//  mem_re         out  1   1-cycle read strobe
//  mem_rdata      in   32  read data, valid exactly 1 cycle after mem_re
//  cpu_hold       out  1   1 = CPU held, loader owns memory port
//  busy           out  1   1 = frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0 except cpu_hold=HOLD_AT_RESET; state IDLE; timer/counters 0.
//  RX: byte captured at edge where rx_data_valid=1 and rx_ack=0; rx_ack=1 next cycle only.
//  Frames (multibyte fields little-endian):
//   0x57 'W' + addr[4] + data[4] -> one write, reply 0x06
//   0x52 'R' + addr[4]           -> one read, reply data[4] LSB first
//   0x48 'H'                     -> cpu_hold=1, reply 0x06
//   0x47 'G'                     -> cpu_hold=0, reply 0x06
//   other                        -> reply 0x15 (NAK), discard byte
//  FSM:
//   IDLE  -cmd W/R-> ADDR; H/G/other -> ACK (hold updated on capture edge)
//   ADDR  4 bytes -> W: DATA, R: READ
//   DATA  4 bytes -> WRITE
//   WRITE mem_we=1 for 1 cycle with addr/wdata -> ACK(0x06)
//   READ  mem_re=1 for 1 cycle -> RWAIT; RWAIT latches mem_rdata -> SEND, idx=0
//   SEND  present byte idx; on transfer idx++; after idx 3 -> IDLE
//   ACK   present reply byte; on transfer -> IDLE
//  Addr bits[1:0] from host forced to 0. W/R do not depend on cpu_hold; host must hold first.
//  tx_data_valid asserted in SEND/ACK only; drops the cycle after last transfer.
//  Timeout: in ADDR/DATA, counter clears per captured byte; at TIMEOUT_CYCLES without byte,
//   abort -> IDLE, no memory access, no reply. IDLE/WRITE/READ/RWAIT/SEND/ACK never time out.
//  Bytes arriving while in WRITE..ACK are not consumed (no rx_ack) until back in IDLE.
//  Async reset mid-frame: immediate IDLE; a partial frame never writes memory.
//  mem_we and mem_re never both 1; each at most 1 cycle per frame.
// TESTING
//  1 reset -> cpu_hold=1, all other outputs 0, busy=0.
//  2 57 10 00 00 00 EF BE AD DE -> one mem_we, addr 0x00000010, wdata 0xDEADBEEF; tx 0x06.
//  3 after (2): 52 13 00 00 00 -> mem_re at addr 0x00000010; tx EF BE AD DE; tx_ready
//    low 5 cycles on byte 2 -> tx_data held at 0xAD, no loss or duplication.
//  4 0x47 -> cpu_hold=0, tx 0x06; 0x48 -> cpu_hold=1, tx 0x06; 0xFF -> tx 0x15, hold unchanged.
//  5 57 + 2 addr bytes then silence TIMEOUT_CYCLES -> busy=0, no mem_we, no tx;
//    next full 'W' frame executes normally.
//  6 rst pulse after 7 bytes of a 'W' frame -> no mem_we ever; 9-byte frame then works.

Source files
------------

// File: rtl/uart_loader.sv
// ---------------------------------------------------------------------------
// uart_loader
//   UART-side bus initiator. Parses host command frames from the receiver
//   byte stream, performs single-word writes/reads on a memory port and
//   answers through the transmitter byte handshake. Also owns cpu_hold so
//   the host can stop the CPU before downloading a program.
//
//   Frames (multibyte fields little-endian):
//     'W' addr[4] data[4] -> write, reply 0x06
//     'R' addr[4]         -> read, reply data[4] LSB first
//     'H' / 'G'           -> cpu_hold=1 / 0, reply 0x06
//     other               -> reply 0x15
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   rx_data_valid, rx_data, rx_ack   receiver byte handshake (level + ack pulse)
//   tx_data_valid, tx_data, tx_ready transmitter valid/ready handshake
//   mem_addr, mem_wdata, mem_we, mem_re, mem_rdata  memory port
//   cpu_hold                      1 = CPU held, loader owns memory port
//   busy                          1 = frame in progress
// ---------------------------------------------------------------------------
module uart_loader #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit HOLD_AT_RESET  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_data_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    output logic        tx_data_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        cpu_hold,
    output logic        busy
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] ACK_B = 8'h06;
    localparam logic [7:0] NAK_B = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_RWAIT, S_SEND, S_ACK
    } state_t;

    state_t          state, state_next;
    logic            is_write;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [1:0]      byte_cnt;
    logic [1:0]      idx;
    logic [7:0]      reply;
    logic [TW-1:0]   timer;

    logic            accepting;
    logic            capture;
    logic            timeout;
    logic            tx_fire;

    // Bytes are only taken while parsing; in WRITE..ACK the receiver is left
    // holding its byte until we return to IDLE.
    assign accepting = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
    assign capture   = accepting && rx_data_valid && !rx_ack;
    assign timeout   = !capture && (timer == TIMER_LAST);
    assign tx_fire   = tx_data_valid && tx_ready;

    // Host-supplied low address bits are ignored: accesses are word-only.
    assign mem_addr  = {addr[31:2], 2'b00};
    assign mem_wdata = wdata;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_next    = state;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        tx_data_valid = 1'b0;
        tx_data       = 8'h00;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (capture)
                    state_next = (rx_data == CMD_W || rx_data == CMD_R) ? S_ADDR : S_ACK;
            end
            S_ADDR: begin
                if (capture && byte_cnt == 2'd3) state_next = is_write ? S_DATA : S_READ;
                else if (timeout)                state_next = S_IDLE;
            end
            S_DATA: begin
                if (capture && byte_cnt == 2'd3) state_next = S_WRITE;
                else if (timeout)                state_next = S_IDLE;
            end
            S_WRITE: begin
                mem_we     = 1'b1;
                state_next = S_ACK;
            end
            S_READ: begin
                mem_re     = 1'b1;
                state_next = S_RWAIT;
            end
            S_RWAIT: state_next = S_SEND;
            S_SEND: begin
                tx_data_valid = 1'b1;
                tx_data       = rdata[{idx, 3'b000} +: 8];
                if (tx_ready && idx == 2'd3) state_next = S_IDLE;
            end
            S_ACK: begin
                tx_data_valid = 1'b1;
                tx_data       = reply;
                if (tx_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ack   <= 1'b0;
            cpu_hold <= HOLD_AT_RESET;
            is_write <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
            byte_cnt <= '0;
            idx      <= '0;
            reply    <= '0;
            timer    <= '0;
        end else begin
            rx_ack <= capture;

            // Idle gap timer only runs while a frame is being parsed.
            if (state == S_ADDR || state == S_DATA)
                timer <= (capture || timeout) ? '0 : timer + TW'(1);
            else
                timer <= '0;

            case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    if (capture) begin
                        is_write <= (rx_data == CMD_W);
                        reply    <= ACK_B;
                        if (rx_data == CMD_H)      cpu_hold <= 1'b1;
                        else if (rx_data == CMD_G) cpu_hold <= 1'b0;
                        else if (rx_data != CMD_W && rx_data != CMD_R) reply <= NAK_B;
                    end
                end
                // Shift-in from the top: after four bytes the first one
                // received sits in bits [7:0] (little-endian).
                S_ADDR: if (capture) begin
                    addr     <= {rx_data, addr[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                S_DATA: if (capture) begin
                    wdata    <= {rx_data, wdata[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                S_WRITE: reply <= ACK_B;
                S_RWAIT: begin
                    rdata <= mem_rdata;
                    idx   <= '0;
                end
                S_SEND: if (tx_fire) idx <= idx + 2'd1;
                default: ;
            endcase
        end
    end

endmodule
